// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg: shared types and byte-pair to colour conversion for the CMOS capture path.
package cmos_capture_pkg;

    typedef enum logic [1:0] {
        MODE_RGB565     = 2'd0,
        MODE_RGB444     = 2'd1,
        MODE_YUV_Y      = 2'd2,
        MODE_RGB565_ALT = 2'd3
    } cam_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_ACTIVE
    } capture_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Channels come back MSB-aligned in 8 bits, so slicing the top COLOR_BITS zero-pads narrow channels.
    function automatic rgb8_t to_pixel(cam_mode_e mode, logic [7:0] b0, logic [7:0] b1);
        rgb8_t p;
        p = '{r: {b0[7:3], 3'b0}, g: {b0[2:0], b1[7:5], 2'b0}, b: {b1[4:0], 3'b0}};
        if (mode == MODE_RGB444)
            p = '{r: {b0[3:0], 4'b0}, g: {b1[7:4], 4'b0}, b: {b1[3:0], 4'b0}};
        else if (mode == MODE_YUV_Y)
            p = '{r: b0, g: b0, b: b0};
        return p;
    endfunction

endpackage

// File: rtl/cmos_pixel_assembler.sv
// cmos_pixel_assembler: pairs camera bytes into pixels and flags the strobe that completes each pixel.
module cmos_pixel_assembler
    import cmos_capture_pkg::*;
#(
    parameter int COLOR_BITS = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      pixel_en_i,
    input  logic                      href_i,
    input  logic                      clr_i,
    input  logic [7:0]                data_i,
    input  logic [1:0]                mode_i,
    output logic                      phase_o,
    output logic                      pix_valid_o,
    output logic [3*COLOR_BITS-1:0]   pixel_o
);

    logic [7:0] b0;
    rgb8_t      p;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            phase_o <= 1'b0;
            b0      <= '0;
        end else if (clr_i) begin
            phase_o <= 1'b0;
        end else if (pixel_en_i) begin
            phase_o <= href_i & ~phase_o;
            if (href_i && !phase_o) b0 <= data_i;
        end
    end

    assign pix_valid_o = pixel_en_i & href_i & phase_o;
    assign p           = to_pixel(cam_mode_e'(mode_i), b0, data_i);
    assign pixel_o     = {p.r[7 -: COLOR_BITS], p.g[7 -: COLOR_BITS], p.b[7 -: COLOR_BITS]};

endmodule

// File: rtl/cmos_frame_capture.sv
// cmos_frame_capture: OV7670 byte stream to decimated VRAM writes with frame status and geometry errors.
// Define CMOS_CAPTURE_TEST_PATTERN_EN to add test_pattern_i, which substitutes 8 vertical colour bars.
module cmos_frame_capture
    import cmos_capture_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int DECIMATE       = 2,
    parameter int COLOR_BITS     = 4,
    parameter int ADDR_WIDTH     = $clog2((ACTIVE_COLUMNS/DECIMATE)*(ACTIVE_ROWS/DECIMATE))
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pixel_en_i,
    input  logic                     vsync_i,
    input  logic                     href_i,
    input  logic [7:0]               data_i,
    input  logic [1:0]               mode_i,
    input  logic                     capture_en_i,
`ifdef CMOS_CAPTURE_TEST_PATTERN_EN
    input  logic                     test_pattern_i,
`endif
    output logic                     wr_en_o,
    output logic [ADDR_WIDTH-1:0]    wr_addr_o,
    output logic [3*COLOR_BITS-1:0]  wr_data_o,
    output logic                     frame_start_o,
    output logic                     frame_done_o,
    output logic [7:0]               frame_count_o,
    output logic                     error_o
);

    localparam int CW = $clog2(ACTIVE_COLUMNS + 1);
    localparam int RW = $clog2(ACTIVE_ROWS + 1);
    localparam int DW = DECIMATE > 1 ? $clog2(DECIMATE) : 1;
    localparam logic [CW-1:0] COL_MAX  = CW'(ACTIVE_COLUMNS);
    localparam logic [RW-1:0] ROW_MAX  = RW'(ACTIVE_ROWS);
    // Keep limits trimmed to whole decimation groups so the address range is never overrun.
    localparam logic [CW-1:0] COL_KEEP = CW'((ACTIVE_COLUMNS/DECIMATE)*DECIMATE);
    localparam logic [RW-1:0] ROW_KEEP = RW'((ACTIVE_ROWS/DECIMATE)*DECIMATE);
    localparam logic [DW-1:0] DMAX     = DW'(DECIMATE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'((ACTIVE_COLUMNS/DECIMATE)*(ACTIVE_ROWS/DECIMATE) - 1);

    capture_state_e            state, state_n;
    logic                      vs_q, hr_q;
    logic [1:0]                mode_q;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [DW-1:0]             xd, yd;
    logic                      phase, pix_valid;
    logic [3*COLOR_BITS-1:0]   pixel, pix_out;
    logic                      active, start, done, href_fall, keep, err_evt;

    cmos_pixel_assembler #(.COLOR_BITS(COLOR_BITS)) u_asm (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pixel_en_i  (pixel_en_i),
        .href_i      (href_i),
        .clr_i       (start),
        .data_i      (data_i),
        .mode_i      (mode_q),
        .phase_o     (phase),
        .pix_valid_o (pix_valid),
        .pixel_o     (pixel)
    );

`ifdef CMOS_CAPTURE_TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar     = 3'(int'(col) / (ACTIVE_COLUMNS/8));
    assign pix_out = test_pattern_i ?
        {{COLOR_BITS{~bar[1]}}, {COLOR_BITS{~bar[2]}}, {COLOR_BITS{~bar[0]}}} : pixel;
`else
    assign pix_out = pixel;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == ST_IDLE && capture_en_i) state_n = ST_WAIT_VS;
        if (start) state_n = ST_ACTIVE;
        if (done)  state_n = ST_IDLE;
    end

    always_comb begin
        active    = state == ST_ACTIVE;
        start     = state == ST_WAIT_VS && pixel_en_i && vs_q && !vsync_i;
        done      = active && pixel_en_i && !vs_q && vsync_i;
        href_fall = active && pixel_en_i && hr_q && !href_i;
        keep      = active && pix_valid && xd == '0 && yd == '0 && col < COL_KEEP && row < ROW_KEEP;
        err_evt   = active && ((pix_valid && (col >= COL_MAX || row >= ROW_MAX)) || (href_fall && phase));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
            error_o       <= 1'b0;
            vs_q          <= 1'b0;
            hr_q          <= 1'b0;
            mode_q        <= '0;
            col           <= '0;
            row           <= '0;
            xd            <= '0;
            yd            <= '0;
        end else begin
            wr_en_o       <= keep;
            frame_start_o <= start;
            frame_done_o  <= done;
            if (wr_en_o && wr_addr_o != LAST_ADDR) wr_addr_o <= wr_addr_o + 1'b1;
            if (keep) wr_data_o <= pix_out;
            if (pixel_en_i) begin
                vs_q <= vsync_i;
                hr_q <= href_i;
            end
            if (done) frame_count_o <= frame_count_o + 1'b1;
            if (err_evt) error_o <= 1'b1;
            if (active && pix_valid && col != COL_MAX) begin
                col <= col + 1'b1;
                xd  <= xd == DMAX ? '0 : xd + 1'b1;
            end
            if (href_fall) begin
                col <= '0;
                xd  <= '0;
                row <= row == ROW_MAX ? row : row + 1'b1;
                yd  <= yd == DMAX ? '0 : yd + 1'b1;
            end
            if (start) begin
                wr_addr_o <= '0;
                col       <= '0;
                row       <= '0;
                xd        <= '0;
                yd        <= '0;
                error_o   <= 1'b0;
                mode_q    <= mode_i;
            end
        end
    end

endmodule
